// File: rtl/clz_ctrl_if.sv
// Handshake bundle between the execute stage (master) and the CLZ/CLO sequencer (slave).
interface clz_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int RW    = $clog2(WIDTH) + 1
);
    logic             start;
    logic             op_clo;
    logic [WIDTH-1:0] operand;
    logic             flush;
    logic             busy;
    logic             done;
    logic [RW-1:0]    result;

    modport master (
        output start, op_clo, operand, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op_clo, operand, flush,
        output busy, done, result
    );
endinterface

// File: rtl/clz_ctrl.sv
// Multi-cycle CLZ/CLO sequencer: scans the latched operand CHUNK bits per cycle
// from the MSB with a narrow leading-zero encoder and accumulates the count.
module clz_ctrl #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    clz_ctrl_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int RW     = $clog2(WIDTH) + 1;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);
    localparam logic [RW-1:0] CHUNK_RW = RW'(CHUNK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [RW-1:0]    count_q, count_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [RW-1:0]    result_q, result_d;

    logic [CHUNK-1:0] top;
    logic [RW-1:0]    top_lz;
    logic             accept;

    // Narrow encoder: leading zeros of one chunk, only meaningful when top != 0.
    function automatic logic [RW-1:0] lz_chunk(input logic [CHUNK-1:0] v);
        logic [RW-1:0] n;
        logic          seen;
        n    = '0;
        seen = 1'b0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (v[i])
                seen = 1'b1;
            else if (!seen)
                n = n + RW'(1);
        end
        return n;
    endfunction

    assign top    = sreg_q[WIDTH-1 -: CHUNK];
    assign top_lz = lz_chunk(top);

    // Flush always wins over a new request; SCAN never accepts.
    assign accept = bus.start && !bus.flush && (state_q != SCAN);

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        count_d  = count_q;
        idx_d    = idx_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (accept)
                    state_d = SCAN;
            end
            SCAN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (top == '0) begin
                    if (idx_q == LAST_IDX) begin
                        result_d = count_q + CHUNK_RW;
                        state_d  = DONE;
                    end else begin
                        count_d = count_q + CHUNK_RW;
                        sreg_d  = sreg_q << CHUNK;
                        idx_d   = idx_q + IW'(1);
                    end
                end else begin
                    result_d = count_q + top_lz;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = accept ? SCAN : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // CLO is CLZ of the inverted operand; load overrides any scan update.
        if (accept) begin
            sreg_d  = bus.op_clo ? ~bus.operand : bus.operand;
            count_d = '0;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q == SCAN);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
endmodule

// File: doc/clz_ctrl.md
Name: clz_ctrl

Overview:
- Multi-cycle sequencer for the count-leading-zeros / count-leading-ones (CLZ/CLO) instructions of the CPU.
- Latches a WIDTH-bit operand and scans it CHUNK bits per cycle from the MSB, using a narrow per-chunk leading-zero encoder.
- Accumulates the count and returns it to the execute stage with a start/busy/done handshake.
- Trades area for latency: a small encoder reused across cycles instead of a full-width priority encoder.

Parameters:
- WIDTH, 32, operand width in bits; power of two, ≥ 8.
- CHUNK, 4, bits examined per scan cycle; power of two; must divide WIDTH; ≥ 2.
- NCHUNK is derived: WIDTH/CHUNK.
- RW is derived: $clog2(WIDTH)+1, the result width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a count; sampled on a rising clk edge.
- op_clo  in  1  0 = count leading zeros, 1 = count leading ones; sampled with start.
- operand  in  WIDTH  value to scan; sampled with start.
- flush  in  1  synchronous abort from pipeline flush.
- busy  out  1  high while state is SCAN.
- done  out  1  one-cycle pulse; result valid.
- result  out  RW  count, range 0..WIDTH; held until the next accepted start.

Behaviour:
- Reset, asynchronous, on rst_n=0:
  - state goes to IDLE.
  - shift register, count and chunk index are cleared.
  - busy=0, done=0, result=0.
- States: IDLE, SCAN, DONE. busy=(state==SCAN); done=(state==DONE).
- Accept: start=1 in IDLE or DONE, with flush=0.
  - sreg <= op_clo ? ~operand : operand.
  - count <= 0, idx <= 0.
  - Go to SCAN.
- Start ignored: start while in SCAN is ignored, with no queueing. The requester must wait for done.
- Back-to-back: start during the DONE cycle is accepted, and the next cycle is SCAN.
- SCAN, each cycle, examines top = sreg[WIDTH-1 -: CHUNK]:
  - If top==0 and idx<NCHUNK-1: count += CHUNK; sreg <<= CHUNK; idx++; stay in SCAN.
  - If top==0 and idx==NCHUNK-1: result <= count+CHUNK, which equals WIDTH; go to DONE.
  - If top!=0: result <= count + lz(top), where lz is the leading zeros of top, 0..CHUNK-1; go to DONE.
- DONE lasts one cycle. Without an accept, the next state is IDLE.
- Latency:
  - z = number of leading all-zero chunks of the (possibly inverted) operand.
  - n = min(z+1, NCHUNK) scan cycles.
  - done is high in the (n+1)th cycle after the cycle in which start was sampled.
  - Best case 2 cycles; worst case NCHUNK+1, which is 9 at the defaults.
- Arithmetic: count and result are RW bits unsigned and never overflow, since the maximum is WIDTH.
- flush=1 has priority over start:
  - From SCAN or DONE, go to IDLE next cycle.
  - No done pulse; result keeps its previous value.
  - In IDLE, flush has no effect except to block start.
- Reset mid-SCAN: immediate IDLE, outputs go to their reset values, and no done is produced.
- The operand is not required to be stable after the accept edge.

Test Plan:
- Reset: hold rst_n=0 mid-SCAN on operand 0 → busy, done and result go to 0 immediately without waiting for clk; after release, state is IDLE.
- CLZ boundaries at defaults:
  - 0x80000000 → result=0, done 2 cycles after start.
  - 0x00000000 → result=32, done 9 cycles after, busy high for 8 cycles.
  - 0x00000001 → result=31, done 9 cycles after.
- Mid-chunk CLZ: 0x00010000 → result=15, done 5 cycles after start; 0x00F00000 → result=8, done 4 cycles after.
- CLO:
  - op_clo=1, 0xFFFFFFFF → result=32.
  - op_clo=1, 0xF0000000 → result=4, done 3 cycles after.
  - op_clo=1, 0x7FFFFFFF → result=0.
- Handshake:
  - start re-asserted during SCAN with a different operand is ignored; the first result is 15 for 0x00010000.
  - start in the DONE cycle with 0x80000000 → second done 2 cycles later with result=0, no IDLE cycle between.
- Flush: flush=1 in the 3rd SCAN cycle of operand 0 → IDLE next cycle, no done, result retains its prior value; a simultaneous start+flush in IDLE is not accepted.
